// File: rtl/hh_pkg.sv
// Shared constants and small types for the Hybrid Hamming interleave path.
package hh_pkg;
  localparam int WORD_W    = 11;
  localparam int NUM_WORDS = 4;
  localparam int FRAME_W   = 44;

  // Word position inside a frame (fill side and drain side)
  typedef logic [1:0] idx_t;
  // Selects one of the two ping-pong banks
  typedef logic       ptr_t;
endpackage

// File: rtl/interleave_frame_ctrl_ilv.sv
// Fixed 44-bit block interleaver: bit j of input word k moves to output
// stream position 4j+k, with stream position 0 being the frame MSB.
module interleave_frame_ctrl_ilv
  import hh_pkg::*;
(
  input  logic [FRAME_W-1:0] bank_i,
  output logic [FRAME_W-1:0] frame_o
);

  // Pure wiring: transpose the 11x4 bit matrix
  for (genvar j = 0; j < WORD_W; j++) begin : g_bit
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
      assign frame_o[FRAME_W-1-(NUM_WORDS*j+k)] = bank_i[FRAME_W-1-j-WORD_W*k];
    end
  end

endmodule

// File: rtl/interleave_frame_ctrl.sv
// Ping-pong frame sequencer around the block interleaver. One bank fills from
// the encoder stream while the other drains to the channel side.
// Handshake: a word moves on a port in any cycle where valid & ready are both
// high at the rising clock edge; valid never depends on ready and in_ready
// depends only on registered state.
module interleave_frame_ctrl
  import hh_pkg::*;
#(
  parameter int NUM_WORDS = 4,
  parameter int WORD_W    = 11,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              pad_evt,
  output logic [CNT_W-1:0]  frames_done
);

  if (NUM_WORDS != 4 || WORD_W != 11) begin : g_bad_params
    $error("interleave_frame_ctrl supports only NUM_WORDS=4 and WORD_W=11");
  end

  logic [FRAME_W-1:0] bank_q [2];
  logic [FRAME_W-1:0] bank_d [2];
  logic [1:0]         full_q, full_d;
  logic [1:0]         byp_q, byp_d;
  ptr_t               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  idx_t               fill_q, fill_d, drain_q, drain_d;
  logic               pad_q, pad_d;
  logic [CNT_W-1:0]   done_q, done_d;

  logic               acc, close_frame, hs, drain_end;
  logic [FRAME_W-1:0] ilv_out, frame;

  assign in_ready    = !full_q[wr_ptr_q];
  assign out_valid   = full_q[rd_ptr_q];
  assign acc         = in_valid & in_ready;
  assign close_frame = acc & (in_last | (fill_q == 2'd3));
  assign hs          = out_valid & out_ready;
  assign drain_end   = hs & (drain_q == 2'd3);

  // Fill side: the first word of a frame clears the rest of the bank, so any
  // words left unwritten by an early in_last are already zero at close.
  always_comb begin
    bank_d   = bank_q;
    byp_d    = byp_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    pad_d    = 1'b0;
    if (acc) begin
      if (fill_q == 2'd0) begin
        bank_d[wr_ptr_q] = {in_data, {(FRAME_W-WORD_W){1'b0}}};
        byp_d[wr_ptr_q]  = bypass;
      end else begin
        bank_d[wr_ptr_q][FRAME_W-1-WORD_W*int'(fill_q) -: WORD_W] = in_data;
      end
      if (close_frame) begin
        pad_d    = (fill_q != 2'd3);
        wr_ptr_d = ~wr_ptr_q;
        fill_d   = 2'd0;
      end else begin
        fill_d = fill_q + 2'd1;
      end
    end
  end

  // Drain side and bank ownership: close marks the fill bank full, the last
  // output handshake frees the drain bank. Both can never name the same bank.
  always_comb begin
    full_d   = full_q;
    rd_ptr_d = rd_ptr_q;
    drain_d  = drain_q;
    done_d   = done_q;
    if (close_frame) full_d[wr_ptr_q] = 1'b1;
    if (hs) begin
      if (drain_end) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
        drain_d          = 2'd0;
        done_d           = done_q + 1'b1;
      end else begin
        drain_d = drain_q + 2'd1;
      end
    end
  end

  // State registers; reset discards both banks and any partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      full_q    <= '0;
      byp_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      fill_q    <= '0;
      drain_q   <= '0;
      pad_q     <= 1'b0;
      done_q    <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      full_q    <= full_d;
      byp_q     <= byp_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      drain_q   <= drain_d;
      pad_q     <= pad_d;
      done_q    <= done_d;
    end
  end

  interleave_frame_ctrl_ilv u_ilv (
    .bank_i  (bank_q[rd_ptr_q]),
    .frame_o (ilv_out)
  );

  assign frame       = byp_q[rd_ptr_q] ? bank_q[rd_ptr_q] : ilv_out;
  assign out_data    = out_valid ? frame[FRAME_W-1-WORD_W*int'(drain_q) -: WORD_W] : '0;
  assign out_last    = out_valid & (drain_q == 2'd3);
  assign pad_evt     = pad_q;
  assign frames_done = done_q;

endmodule

// File: tb/tb_interleave_frame_ctrl.sv
// Bench for interleave_frame_ctrl: directed and random frames against a
// bit-stream reference model, checked by a scoreboard monitor.
module tb_interleave_frame_ctrl;

  typedef struct {
    logic [10:0] data;
    logic        last;
    logic        byp;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        bypass = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [10:0] out_data;
  logic        out_last;
  logic        pad_evt;
  logic [15:0] frames_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random
  int gap_pct = 0;
  int pad_seen = 0;
  int exp_pad = 0;
  int closed = 0;

  stim_t       stim_q[$];
  logic [11:0] exp_q[$];   // {last, data}
  int          acc_cyc[$];
  int          out_cyc[$];

  logic [10:0] m_w[4];
  int          m_cnt = 0;
  logic        m_byp = 1'b0;

  interleave_frame_ctrl #(.NUM_WORDS(4), .WORD_W(11), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .bypass      (bypass),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .pad_evt     (pad_evt),
    .frames_done (frames_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  // Frame = 44-bit stream, position 0 first. Interleaving sends stream
  // position j+11k (bit j of word k) to position 4j+k.
  task automatic push_frame();
    logic bs[44];
    logic fs[44];
    logic [10:0] word;
    for (int s = 0; s < 44; s++) bs[s] = m_w[s/11][10 - s%11];
    for (int j = 0; j < 11; j++)
      for (int k = 0; k < 4; k++)
        fs[4*j+k] = m_byp ? bs[4*j+k] : bs[j+11*k];
    for (int w = 0; w < 4; w++) begin
      word = '0;
      for (int b = 0; b < 11; b++) word = {word[9:0], fs[11*w+b]};
      exp_q.push_back({(w == 3) ? 1'b1 : 1'b0, word});
    end
  endtask

  task automatic model_accept(input stim_t s);
    if (m_cnt == 0) m_byp = s.byp;
    m_w[m_cnt] = s.data;
    m_cnt++;
    if (m_cnt == 4 || s.last) begin
      if (m_cnt < 4) exp_pad++;
      for (int i = m_cnt; i < 4; i++) m_w[i] = '0;
      push_frame();
      m_cnt = 0;
      closed++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; acceptance is judged at the following negedge.
  task automatic run_stim(input int budget);
    int n = 0;
    while (stim_q.size() > 0 && n < budget) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = stim_q[0].data;
      in_last  = stim_q[0].last;
      bypass   = stim_q[0].byp;
      @(negedge clk);
      if (in_valid && in_ready) begin
        model_accept(stim_q[0]);
        acc_cyc.push_back(cyc + 1);
        void'(stim_q.pop_front());
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic add_word(input logic [10:0] d, input logic last, input logic byp);
    stim_t s;
    s.data = d; s.last = last; s.byp = byp;
    stim_q.push_back(s);
  endtask

  task automatic add_frame_7ff(input logic byp);
    add_word(11'h7FF, 1'b0, byp);
    add_word(11'h000, 1'b0, byp);
    add_word(11'h000, 1'b0, byp);
    add_word(11'h000, 1'b0, byp);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    rdy_mode = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", (n >= budget) ? 1 : 0, 0);
    chk("frames_done", frames_done, closed[15:0]);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pad_evt", pad_evt, 0);
    chk("rst_frames_done", frames_done, 0);
    exp_q.delete();
    stim_q.delete();
    m_cnt = 0;
    closed = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- out_ready generator ----------------
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 99) < 70);
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (pad_evt) pad_seen++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {out_last, out_data}, 12'hFFF);
        end else begin
          chk(out_ready ? "out_word" : "out_hold", {20'd0, out_last, out_data}, {20'd0, exp_q[0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            out_cyc.push_back(cyc);
          end
        end
      end else begin
        chk("idle_last", out_last, 0);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("por_in_ready", in_ready, 1);
    chk("por_out_valid", out_valid, 0);
    chk("por_out_data", out_data, 0);
    chk("por_out_last", out_last, 0);
    chk("por_pad_evt", pad_evt, 0);
    chk("por_frames_done", frames_done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // interleaved frame, then bypassed frame
    add_frame_7ff(1'b0);
    run_stim(100);
    wait_drain(100);
    chk("no_pad", pad_seen, 0);
    add_frame_7ff(1'b1);
    run_stim(100);
    wait_drain(100);

    // short frame padded
    add_word(11'h7FF, 1'b1, 1'b0);
    run_stim(100);
    wait_drain(100);
    chk("pad_once", pad_seen, 1);
    chk("pad_count", pad_seen, exp_pad);

    // backpressure: 12 offered, 8 accepted while stalled
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    add_frame_7ff(1'b0);
    add_frame_7ff(1'b0);
    add_frame_7ff(1'b0);
    run_stim(20);
    chk("bp_left", stim_q.size(), 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data", out_data, 11'h444);
    rdy_mode = 0;
    run_stim(100);
    chk("bp_rest_taken", stim_q.size(), 0);
    wait_drain(200);

    // three frames back-to-back: latency and throughput
    acc_cyc.delete();
    out_cyc.delete();
    for (int i = 0; i < 12; i++) add_word(11'($urandom_range(0, 2047)), 1'b0, 1'($urandom_range(0, 1)));
    run_stim(100);
    wait_drain(100);
    chk("b2b_in_cycles", acc_cyc[11] - acc_cyc[0], 11);
    chk("b2b_out_count", out_cyc.size(), 12);
    chk("b2b_latency", out_cyc[0], acc_cyc[3]);
    chk("b2b_out_cycles", out_cyc[11] - out_cyc[0], 11);

    // reset during fill
    add_word(11'h123, 1'b0, 1'b0);
    add_word(11'h456, 1'b0, 1'b0);
    run_stim(100);
    do_reset();
    add_frame_7ff(1'b0);
    run_stim(100);
    wait_drain(100);

    // reset during drain
    for (int i = 0; i < 4; i++) add_word(11'($urandom_range(0, 2047)), 1'b0, 1'b0);
    run_stim(100);
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 4; i++) add_word(11'($urandom_range(0, 2047)), 1'b0, 1'b0);
    run_stim(100);
    wait_drain(100);

    // random traffic with random stalls, gaps and short frames
    pad_seen = 0;
    exp_pad = 0;
    rdy_mode = 2;
    gap_pct = 20;
    for (int i = 0; i < 120; i++)
      add_word(11'($urandom_range(0, 2047)), ($urandom_range(0, 99) < 15), 1'($urandom_range(0, 1)));
    add_word(11'($urandom_range(0, 2047)), 1'b1, 1'b0);
    run_stim(3000);
    chk("rand_all_taken", stim_q.size(), 0);
    gap_pct = 0;
    wait_drain(500);
    chk("rand_pad_count", pad_seen, exp_pad);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interleave_frame_ctrl.md
Name: interleave_frame_ctrl

Overview:
Frame sequencer for the fixed 44-bit block interleaver in the Hybrid Hamming encode path. It collects 11-bit Hamming codewords from the encoder over a valid/ready stream and assembles them into 44-bit frames of 4 words. Each completed frame passes through the interleaver, and the result is re-serialised as 4 words to the channel side. Ping-pong buffering lets one frame fill while the previous one drains, sustaining one word per cycle.

Parameters:
NUM_WORDS, 4, codewords per frame; only 4 is legal (elaboration-time check)
WORD_W, 11, codeword width; only 11 is legal (elaboration-time check)
CNT_W, 16, width of frames_done counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  controller can accept a word
in_data  input  11  codeword
in_last  input  1  final word of a (possibly short) frame; qualified by in_valid & in_ready
bypass  input  1  1 = skip interleaving for this frame; sampled with the frame's first word
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts word
out_data  output  11  interleaved (or bypassed) word
out_last  output  1  high on word 3 of each output frame
pad_evt  output  1  one-cycle pulse when a short frame is zero-padded
frames_done  output  CNT_W  count of fully drained frames, wraps

Behaviour:
- Reset (asynchronous, active-high): both banks empty, wr_ptr=rd_ptr=0, fill and drain indices 0. After reset, in_ready=1, out_valid=0, out_last=0, pad_evt=0, frames_done=0, out_data=0. Inputs are ignored while rst=1.
- Reset mid-operation discards all buffered and partially drained data. No partial frame is emitted afterwards.
- Storage: two 44-bit banks, each with a full flag and a per-frame bypass flag.
- Fill side:
  - in_ready = !full[wr_ptr].
  - An accepted word at fill index i is written to bank[wr_ptr][43-11i -: 11]; word 0 occupies the MSBs.
- Frame close: occurs on acceptance at i=3, or on in_last at any i.
  - Any unwritten words are forced to 0.
  - pad_evt pulses the following cycle, only if i<3.
  - full[wr_ptr] is set, wr_ptr toggles, and i returns to 0.
  - in_last at i=3 is a normal close with no pad.
- Drain side:
  - out_valid = full[rd_ptr].
  - Frame F = bank, or interleaver(bank) when bypass=0.
  - Interleave map: F[43-(4j+k)] = bank[43-j-11k], for j=0..10, k=0..3.
  - out_data at drain index k = F[43-11k -: 11]; out_last = out_valid & (k==3).
  - Each out_valid & out_ready advances k.
  - On the k=3 handshake: full[rd_ptr] clears, rd_ptr toggles, k=0, frames_done increments (wrapping modulo 2^CNT_W).
- Latency: the first output word is valid in the cycle after the clock edge that accepts the closing input word.
- Stability: out_data, out_last and out_valid hold while out_valid & !out_ready, because a full bank is never written.
- Bank ordering: banks fill and drain strictly alternately, so frames leave in order.
- Simultaneous fill and drain always touch different banks, or the same bank only after it was freed.
- No combinational path from out_ready to in_ready. A bank freed at edge t makes in_ready rise after t.
- Steady state with out_ready=1 sustains 1 word/cycle in and out.
- Backpressure: with the output stalled, at most 8 words are accepted, then in_ready=0.

Decomposition:
- Shared package hh_pkg:
  - WORD_W=11, NUM_WORDS=4, FRAME_W=44.
  - The fill/drain index typedef (2 bits).
  - The bank pointer typedef.
- Sub-module: the existing combinational interleaver (44-bit in/out), instanced once on the drain-bank read path.
- The fill and drain logic are two small always-blocks, not separate modules.

Test Plan:
- Words 0x7FF,0,0,0, bypass=0, out_ready=1 -> out 0x444,0x222,0x111,0x088; out_last on the 4th; frames_done=1; no pad_evt.
- Same words with bypass=1 -> out 0x7FF,0x000,0x000,0x000.
- Single word 0x7FF with in_last=1 -> pad_evt pulses once; output 0x444,0x222,0x111,0x088.
- out_ready=0, 12 input words offered -> exactly 8 accepted, then in_ready=0; out_data stays 0x444 (frame 1 word 0). Releasing out_ready drains 8 words in order, then the remaining 4 are accepted.
- 3 frames back-to-back, both sides always ready -> 12 output words on 12 consecutive cycles, starting 1 cycle after the 4th input acceptance; frames_done=3.
- rst pulsed after 2 words of a frame, or mid-drain -> out_valid=0 and in_ready=1 immediately; next full frame outputs correctly; frames_done restarts from 0.
